// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared pixel/colour definitions and grant encoding for the VRAM arbiter
package vram_arbiter_pkg;
  localparam int COLOR_W = 3;
  localparam int ADDR_W = 16;
  localparam logic [COLOR_W-1:0] COLOR_BLACK = 3'd0;
  localparam logic [COLOR_W-1:0] COLOR_WHITE = 3'd7;
  typedef enum logic [1:0] {IDLE, RD, WR} grant_e;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [COLOR_W-1:0] color;
  } pix_wr_t;
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] row, input logic [7:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: CPU write, display read and VRAM port bundle of the arbiter
interface vram_arbiter_if;
  import vram_arbiter_pkg::*;
  logic cpu_wr_req;
  logic [7:0] cpu_row;
  logic [7:0] cpu_col;
  logic [COLOR_W-1:0] cpu_color;
  logic cpu_full;
  logic disp_rd_req;
  logic [ADDR_W-1:0] disp_addr;
  logic disp_gnt;
  logic disp_rd_valid;
  logic [COLOR_W-1:0] disp_data;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_wr_en;
  logic [COLOR_W-1:0] mem_wr_data;
  logic [COLOR_W-1:0] mem_rd_data;
  modport slave (
    input cpu_wr_req, cpu_row, cpu_col, cpu_color, disp_rd_req, disp_addr, mem_rd_data,
    output cpu_full, disp_gnt, disp_rd_valid, disp_data, mem_addr, mem_wr_en, mem_wr_data
  );
  modport master (
    output cpu_wr_req, cpu_row, cpu_col, cpu_color, disp_rd_req, disp_addr, mem_rd_data,
    input cpu_full, disp_gnt, disp_rd_valid, disp_data, mem_addr, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/vram_write_fifo.sv
// vram_write_fifo: power-of-two CPU pixel-write buffer with registered occupancy count
module vram_write_fifo
  import vram_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic pop_i,
  input  pix_wr_t data_i,
  output pix_wr_t data_o,
  output logic full_o,
  output logic empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  pix_wr_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end
  end
  assign data_o = mem_q[rd_ptr_q];
  assign full_o = count_q == (AW + 1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between buffered CPU pixel writes and display reads,
// favouring the display until pending writes have waited MAX_STARVE display grants
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_STARVE = 8
) (
  input logic clk_i,
  input logic rst_ni,
  vram_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  grant_e state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [COLOR_W-1:0] mem_wr_data_q, disp_data_q;
  logic mem_wr_en_q, disp_valid_q;
  logic full, empty, push, rd_dec, wr_dec, starved;
  logic [CW-1:0] count;
  pix_wr_t head, wr_pix;
  assign push = bus.cpu_wr_req & ~full;
  assign wr_pix = '{addr: pix_addr(bus.cpu_row, bus.cpu_col), color: bus.cpu_color};
  always_comb begin
    starved = starve_q == SW'(MAX_STARVE);
    rd_dec = bus.disp_rd_req & ~(~empty & starved);
    wr_dec = ~rd_dec & ~empty;
    state_d = rd_dec ? RD : (wr_dec ? WR : IDLE);
    starve_d = (empty | wr_dec) ? '0 : (starved ? starve_q : starve_q + 1'b1);
  end
  vram_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (wr_dec),
    .data_i  (wr_pix),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  // Read data is captured in the cycle after the grant's address reaches VRAM
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      starve_q <= '0;
      mem_addr_q <= '0;
      mem_wr_data_q <= '0;
      mem_wr_en_q <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q <= '0;
    end else begin
      state_q <= state_d;
      starve_q <= starve_d;
      mem_wr_en_q <= state_d == WR;
      if (state_d == RD) mem_addr_q <= bus.disp_addr;
      if (state_d == WR) begin
        mem_addr_q <= head.addr;
        mem_wr_data_q <= head.color;
      end
      disp_valid_q <= state_q == RD;
      if (state_q == RD) disp_data_q <= bus.mem_rd_data;
    end
  end
  always @(posedge clk_i) if (rst_ni) assert (empty == (count == '0));
  assign bus.cpu_full = full;
  assign bus.disp_gnt = rd_dec & rst_ni;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wr_en = mem_wr_en_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.disp_rd_valid = disp_valid_q;
  assign bus.disp_data = disp_data_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a behavioural VRAM
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;
  typedef struct {
    int due;
    logic [COLOR_W-1:0] data;
  } rd_exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  pix_wr_t exp_wr[$];
  rd_exp_t exp_rd[$];
  pix_wr_t e;
  rd_exp_t r;
  logic [COLOR_W-1:0] vram [65536];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  vram_arbiter_if bus();
  vram_arbiter #(.FIFO_DEPTH(4), .MAX_STARVE(8)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  assign bus.mem_rd_data = vram[bus.mem_addr];
  always @(posedge clk) if (bus.mem_wr_en) vram[bus.mem_addr] <= bus.mem_wr_data;

  // scoreboard: writes in push order, reads due two cycles after their grant
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_wr_en) begin
        tests++;
        if (exp_wr.size() == 0) begin
          fails++;
          $display("FAIL sb_wr_unexpected: got addr=%h data=%0d, expected no write", bus.mem_addr, bus.mem_wr_data);
        end else begin
          e = exp_wr.pop_front();
          if ({bus.mem_addr, bus.mem_wr_data} !== {e.addr, e.color}) begin
            fails++;
            $display("FAIL sb_wr_order: got addr=%h data=%0d, expected addr=%h data=%0d", bus.mem_addr, bus.mem_wr_data, e.addr, e.color);
          end
        end
      end
      if (bus.disp_rd_valid) begin
        tests++;
        if (exp_rd.size() == 0) begin
          fails++;
          $display("FAIL sb_rd_unexpected: got data=%0d at cycle %0d, expected no read data", bus.disp_data, cyc);
        end else begin
          r = exp_rd.pop_front();
          if (r.due != cyc || bus.disp_data !== r.data) begin
            fails++;
            $display("FAIL sb_rd: got data=%0d at cycle %0d, expected data=%0d at cycle %0d", bus.disp_data, cyc, r.data, r.due);
          end
        end
      end else if (exp_rd.size() != 0 && exp_rd[0].due == cyc) begin
        tests++;
        fails++;
        $display("FAIL sb_rd_missing: got no valid at cycle %0d, expected data=%0d", cyc, exp_rd[0].data);
        void'(exp_rd.pop_front());
      end
      if (bus.disp_gnt) exp_rd.push_back('{cyc + 2, vram[bus.disp_addr]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.cpu_wr_req = 1'b0;
    bus.disp_rd_req = 1'b0;
  endtask

  task automatic offer(input logic [7:0] row, input logic [7:0] col, input logic [2:0] color, input bit accept);
    bus.cpu_wr_req = 1'b1;
    bus.cpu_row = row;
    bus.cpu_col = col;
    bus.cpu_color = color;
    if (accept) exp_wr.push_back('{addr: {row, col}, color: color});
  endtask

  task automatic test_reset();
    bit bad = 0;
    rst_n = 1'b0;
    offer(8'h11, 8'h22, 3'd3, 0);
    bus.disp_rd_req = 1'b1;
    bus.disp_addr = 16'h0000;
    repeat (2) tick();
    @(negedge clk);
    tests++;
    if (bus.disp_gnt !== 1'b0) begin fails++; $display("FAIL rst_gnt: got %b, expected 0", bus.disp_gnt); end
    tests++;
    if ({bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data} !== 20'h0) begin
      fails++;
      $display("FAIL rst_mem: got en=%b addr=%h data=%0d, expected all 0", bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data);
    end
    tests++;
    if ({bus.disp_rd_valid, bus.disp_data, bus.cpu_full} !== 5'h0) begin
      fails++;
      $display("FAIL rst_disp: got valid=%b data=%0d full=%b, expected 0", bus.disp_rd_valid, bus.disp_data, bus.cpu_full);
    end
    tick();
    rst_n = 1'b1;
    quiet();
    exp_wr.delete();
    exp_rd.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.mem_wr_en !== 1'b0 || bus.cpu_full !== 1'b0) bad = 1;
      tick();
    end
    tests++;
    if (bad) begin fails++; $display("FAIL rst_no_push: got a write or full after reset, expected none"); end
  endtask

  task automatic test_single_write();
    offer(8'h05, 8'h24, COLOR_WHITE, 1);
    tick();
    quiet();
    @(negedge clk);
    tests++;
    if (bus.mem_wr_en !== 1'b0) begin fails++; $display("FAIL single_early: got en=%b, expected 0", bus.mem_wr_en); end
    tick();
    @(negedge clk);
    tests++;
    if ({bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data} !== {1'b1, 16'h0524, COLOR_WHITE}) begin
      fails++;
      $display("FAIL single_write: got en=%b addr=%h data=%0d, expected en=1 addr=0524 data=7", bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data);
    end
    tick();
  endtask

  task automatic test_idle();
    bit bad = 0;
    quiet();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_wr_en !== 1'b0 || bus.mem_addr !== 16'h0524 || bus.mem_wr_data !== COLOR_WHITE) bad = 1;
      tick();
    end
    tests++;
    if (bad) begin fails++; $display("FAIL idle_hold: got activity or changed addr=%h, expected en=0 addr=0524", bus.mem_addr); end
  endtask

  task automatic test_read_stream();
    for (int i = 0; i < 8; i++) begin
      bus.disp_rd_req = i < 4;
      bus.disp_addr = 16'(i);
      @(negedge clk);
      tests++;
      if (bus.disp_gnt !== (i < 4)) begin fails++; $display("FAIL rd_gnt[%0d]: got %b, expected %b", i, bus.disp_gnt, i < 4); end
      if (i >= 2 && i <= 5) begin
        tests++;
        if (bus.disp_rd_valid !== 1'b1 || bus.disp_data !== 3'(i - 1)) begin
          fails++;
          $display("FAIL rd_stream[%0d]: got valid=%b data=%0d, expected valid=1 data=%0d", i, bus.disp_rd_valid, bus.disp_data, i - 1);
        end
      end
      if (i == 6) begin
        tests++;
        if (bus.disp_rd_valid !== 1'b0) begin fails++; $display("FAIL rd_stream_end: got valid=%b, expected 0", bus.disp_rd_valid); end
      end
      tick();
    end
    quiet();
  endtask

  task automatic test_back_to_back();
    bit bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) offer(8'h30 + 8'(i), 8'(i), 3'(i), 1);
      else quiet();
      @(negedge clk);
      if (bus.cpu_full !== 1'b0) bad = 1;
      tests++;
      if (bus.mem_wr_en !== (i >= 2 && i <= 7)) begin
        fails++;
        $display("FAIL b2b_en[%0d]: got %b, expected %b", i, bus.mem_wr_en, i >= 2 && i <= 7);
      end
      tick();
    end
    tests++;
    if (bad) begin fails++; $display("FAIL b2b_full: got full=1, expected 0 throughout"); end
  endtask

  task automatic test_starve();
    int wr_cyc[$];
    int want[4] = '{10, 19, 28, 37};
    bus.disp_addr = 16'h0100;
    for (int i = 0; i < 45; i++) begin
      bus.disp_rd_req = 1'b1;
      if (i < 5) offer(8'h10 + 8'(i), 8'h80 + 8'(i), 3'(i + 2), i < 4);
      else bus.cpu_wr_req = 1'b0;
      @(negedge clk);
      if (i == 3 || i == 4 || i == 10) begin
        tests++;
        if (bus.cpu_full !== (i == 4)) begin fails++; $display("FAIL starve_full[%0d]: got %b, expected %b", i, bus.cpu_full, i == 4); end
      end
      if (i == 9) begin
        tests++;
        if (bus.disp_gnt !== 1'b0) begin fails++; $display("FAIL starve_gnt: got %b, expected 0 on write grant", bus.disp_gnt); end
      end
      if (bus.mem_wr_en) wr_cyc.push_back(i);
      tick();
    end
    quiet();
    tests++;
    if (wr_cyc.size() != 4) begin
      fails++;
      $display("FAIL starve_count: got %0d writes, expected 4", wr_cyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (wr_cyc[k] != want[k]) begin fails++; $display("FAIL starve_time[%0d]: got cycle %0d, expected %0d", k, wr_cyc[k], want[k]); end
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_full_hold();
    bus.disp_addr = 16'h0001;
    for (int i = 0; i < 12; i++) begin
      bus.disp_rd_req = i < 6;
      if (i < 5) offer(8'h50 + 8'(i), 8'h0f, 3'(7 - i), i < 4);
      else bus.cpu_wr_req = 1'b0;
      @(negedge clk);
      if (i == 4) begin
        tests++;
        if (bus.cpu_full !== 1'b1 || bus.disp_gnt !== 1'b1) begin
          fails++;
          $display("FAIL full_push: got full=%b gnt=%b, expected full=1 gnt=1", bus.cpu_full, bus.disp_gnt);
        end
      end
      if (i == 5 || i == 7) begin
        tests++;
        if (bus.cpu_full !== (i == 5)) begin fails++; $display("FAIL full_hold[%0d]: got %b, expected %b", i, bus.cpu_full, i == 5); end
      end
      if (i >= 6) begin
        tests++;
        if (bus.mem_wr_en !== (i >= 7 && i <= 10)) begin
          fails++;
          $display("FAIL full_drain[%0d]: got en=%b, expected %b", i, bus.mem_wr_en, i >= 7 && i <= 10);
        end
      end
      tick();
    end
    quiet();
    repeat (3) tick();
    tests++;
    if (exp_wr.size() != 0) begin fails++; $display("FAIL wr_leftover: got %0d writes never seen, expected 0", exp_wr.size()); end
  endtask

  task automatic test_reset_mid();
    bit bad = 0;
    bus.disp_addr = 16'h0200;
    for (int i = 0; i < 16; i++) begin
      bus.disp_rd_req = i < 4;
      if (i < 2) offer(8'h40 + 8'(i), 8'h01, 3'd5, 1);
      else if (i == 3) offer(8'h44, 8'h01, 3'd5, 0);
      else bus.cpu_wr_req = 1'b0;
      if (i == 3) begin
        rst_n = 1'b0;
        exp_wr.delete();
        exp_rd.delete();
      end else rst_n = 1'b1;
      @(negedge clk);
      if (i == 3) begin
        tests++;
        if (bus.disp_gnt !== 1'b0) begin fails++; $display("FAIL mid_rst_gnt: got %b, expected 0", bus.disp_gnt); end
      end
      if (i == 4) begin
        tests++;
        if (bus.cpu_full !== 1'b0) begin fails++; $display("FAIL mid_rst_full: got %b, expected 0", bus.cpu_full); end
      end
      if (i >= 4 && (bus.disp_rd_valid !== 1'b0 || bus.mem_wr_en !== 1'b0)) bad = 1;
      tick();
    end
    tests++;
    if (bad) begin fails++; $display("FAIL mid_rst_flush: got valid or write after reset, expected none"); end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) vram[a] = COLOR_BLACK;
    for (int a = 0; a < 4; a++) vram[a] = 3'(a + 1);
    vram[16'h0100] = 3'd5;
    vram[16'h0200] = 3'd6;
    bus.cpu_row = '0;
    bus.cpu_col = '0;
    bus.cpu_color = '0;
    bus.disp_addr = '0;
    quiet();
    test_reset();
    test_single_write();
    test_idle();
    test_read_stream();
    test_back_to_back();
    test_starve();
    test_full_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
